dm_master: RTL and testbench

DM_MASTER -- requirements
Module: dm_master

---
 rtl/dm_pkg.sv | 15 +
 rtl/dm_lane_align.sv | 48 ++++
 rtl/dm_master.sv | 125 ++++++++++++
 tb/tb_dm_master.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared encodings for the data-memory master: access sizes and FSM states.
package dm_pkg;

   localparam logic [1:0] SZ_WORD = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_BYTE = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;

   typedef enum logic [1:0] {
      StIdle  = 2'b00,
      StIssue = 2'b01,
      StResp  = 2'b10
   } state_e;

endpackage

// File: rtl/dm_lane_align.sv
// Byte-lane steering: store enables/replicated data and load lane extraction/extension.
module dm_lane_align
   import dm_pkg::*;
(
   input  logic [1:0]  i_size,
   input  logic [1:0]  i_addr_lo,
   input  logic        i_sext,
   input  logic [31:0] i_wdata,
   input  logic [31:0] i_rdata,
   output logic [3:0]  o_be,
   output logic [31:0] o_wdata,
   output logic [31:0] o_load
);

   logic [15:0] w_half;
   logic [7:0]  w_byte;

   always_comb begin
      w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
      w_byte = i_rdata[7:0];
      case (i_addr_lo)
         2'd0:    w_byte = i_rdata[7:0];
         2'd1:    w_byte = i_rdata[15:8];
         2'd2:    w_byte = i_rdata[23:16];
         default: w_byte = i_rdata[31:24];
      endcase
   end

   always_comb begin
      o_be    = 4'b1111;
      o_wdata = i_wdata;
      o_load  = i_rdata;
      case (i_size)
         SZ_HALF: begin
            o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
            o_wdata = {2{i_wdata[15:0]}};
            o_load  = {{16{i_sext & w_half[15]}}, w_half};
         end
         SZ_BYTE: begin
            o_be    = 4'b0001 << i_addr_lo;
            o_wdata = {4{i_wdata[7:0]}};
            o_load  = {{24{i_sext & w_byte[7]}}, w_byte};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/dm_master.sv
// CPU-to-memory access master with ack timeout; optional misalignment trap when
// DM_MASTER_MISALIGN_TRAP_EN is defined.
module dm_master
   import dm_pkg::*;
#(
   parameter int unsigned ACK_TIMEOUT = 16
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_req,
   input  logic        i_we,
   input  logic [1:0]  i_size,
   input  logic        i_sext,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_wdata,
   output logic        o_busy,
   output logic        o_done,
   output logic [31:0] o_rdata,
   output logic        o_fault,
   output logic        o_m_req,
   output logic        o_m_we,
   output logic [31:0] o_m_addr,
   output logic [3:0]  o_m_be,
   output logic [31:0] o_m_wdata,
   input  logic        i_m_ack,
   input  logic [31:0] i_m_rdata
);

   state_e      r_state, w_state_nxt;
   logic        r_we, r_sext, r_fault;
   logic [1:0]  r_size;
   logic [31:0] r_addr, r_wdata, r_rdata;
   logic [7:0]  r_cnt;

   logic        w_misalign, w_legal, w_timeout, w_issue;
   logic [3:0]  w_be;
   logic [31:0] w_wdata, w_load;

`ifdef DM_MASTER_MISALIGN_TRAP_EN
   assign w_misalign = ((i_size == SZ_HALF) && i_addr[0]) ||
                       ((i_size == SZ_WORD) && (i_addr[1:0] != 2'b00));
`else
   assign w_misalign = 1'b0;
`endif

   assign w_legal   = (i_size != SZ_RSVD) && !w_misalign;
   // Last waiting cycle: counter would reach ACK_TIMEOUT on this edge.
   assign w_timeout = (r_cnt == 8'(ACK_TIMEOUT - 1));
   assign w_issue   = (r_state == StIssue);

   dm_lane_align u_lane_align (
      .i_size    (r_size),
      .i_addr_lo (r_addr[1:0]),
      .i_sext    (r_sext),
      .i_wdata   (r_wdata),
      .i_rdata   (i_m_rdata),
      .o_be      (w_be),
      .o_wdata   (w_wdata),
      .o_load    (w_load)
   );

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         StIdle:  if (i_req) w_state_nxt = w_legal ? StIssue : StResp;
         StIssue: if (i_m_ack || w_timeout) w_state_nxt = StResp;
         StResp:  w_state_nxt = StIdle;
         default: w_state_nxt = StIdle;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= StIdle;
         r_we    <= 1'b0;
         r_sext  <= 1'b0;
         r_size  <= 2'b00;
         r_addr  <= 32'd0;
         r_wdata <= 32'd0;
         r_rdata <= 32'd0;
         r_fault <= 1'b0;
         r_cnt   <= 8'd0;
      end else begin
         r_state <= w_state_nxt;
         case (r_state)
            StIdle: begin
               r_cnt <= 8'd0;
               if (i_req) begin
                  r_we    <= i_we;
                  r_sext  <= i_sext;
                  r_size  <= i_size;
                  r_addr  <= i_addr;
                  r_wdata <= i_wdata;
                  r_rdata <= 32'd0;
                  r_fault <= !w_legal;
               end
            end
            StIssue: begin
               if (i_m_ack) begin
                  r_fault <= 1'b0;
                  r_rdata <= r_we ? 32'd0 : w_load;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
                  if (w_timeout) begin
                     r_fault <= 1'b1;
                     r_rdata <= 32'd0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign o_busy    = (r_state != StIdle);
   assign o_done    = (r_state == StResp);
   assign o_rdata   = o_done ? r_rdata : 32'd0;
   assign o_fault   = o_done & r_fault;
   assign o_m_req   = w_issue;
   assign o_m_we    = w_issue & r_we;
   assign o_m_addr  = w_issue ? {r_addr[31:2], 2'b00} : 32'd0;
   assign o_m_be    = w_issue ? w_be : 4'd0;
   assign o_m_wdata = w_issue ? w_wdata : 32'd0;

endmodule

// File: tb/tb_dm_master.sv
// Scoreboard bench for dm_master: stimulus queues expected bus beats and completions,
// a negedge monitor pops and compares them.
module tb_dm_master;

   localparam int unsigned TO = 4;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [7:0]  len;
   } bus_t;

   typedef struct packed {
      logic [31:0] rdata;
      logic        fault;
   } done_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req = 1'b0, we = 1'b0, sext = 1'b0;
   logic [1:0]  size = 2'b00;
   logic [31:0] addr = 32'd0, wdata = 32'd0;
   logic        busy, done, fault, m_req, m_we, m_ack;
   logic [31:0] rdata, m_addr, m_wdata;
   logic [3:0]  m_be;
   logic [31:0] mem_rdata = 32'd0;
   logic        ack_force = 1'b0;
   logic [7:0]  ack_at = 8'hFF;
   logic [7:0]  bcnt;

   int total = 0;
   int bad = 0;

   bus_t  bq[$];
   done_t dq[$];

   dm_master #(.ACK_TIMEOUT(TO)) dut (
      .i_clk     (clk),
      .i_rst_n   (rst_n),
      .i_req     (req),
      .i_we      (we),
      .i_size    (size),
      .i_sext    (sext),
      .i_addr    (addr),
      .i_wdata   (wdata),
      .o_busy    (busy),
      .o_done    (done),
      .o_rdata   (rdata),
      .o_fault   (fault),
      .o_m_req   (m_req),
      .o_m_we    (m_we),
      .o_m_addr  (m_addr),
      .o_m_be    (m_be),
      .o_m_wdata (m_wdata),
      .i_m_ack   (m_ack),
      .i_m_rdata (mem_rdata)
   );

   always #5 clk = ~clk;

   // Memory model: ack on the ack_at-th ISSUE cycle (0-based); 8'hFF never acks.
   always_ff @(posedge clk) bcnt <= m_req ? bcnt + 8'd1 : 8'd0;
   assign m_ack = ack_force | (m_req & (bcnt == ack_at));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // Monitor
   initial begin
      bus_t  cur;
      done_t d;
      int    run;
      logic  cur_ok;
      run = 0;
      cur_ok = 1'b0;
      cur = '0;
      forever begin
         @(negedge clk);
         if (m_req) begin
            if (run == 0) begin
               if (bq.size() == 0) begin
                  chk("unexpected_m_req", 32'd1, 32'd0);
                  cur_ok = 1'b0;
               end else begin
                  cur = bq.pop_front();
                  cur_ok = 1'b1;
               end
            end
            if (cur_ok) begin
               chk("m_we", 32'(m_we), 32'(cur.we));
               chk("m_addr", m_addr, cur.addr);
               chk("m_be", 32'(m_be), 32'(cur.be));
               chk("m_wdata", m_wdata, cur.wdata);
            end
            run++;
         end else if (run != 0) begin
            if (cur_ok && cur.len != 8'd0) chk("m_req_len", 32'(run), 32'(cur.len));
            run = 0;
            cur_ok = 1'b0;
         end
         if (done) begin
            if (dq.size() == 0) begin
               chk("unexpected_done", 32'd1, 32'd0);
            end else begin
               d = dq.pop_front();
               chk("rdata", rdata, d.rdata);
               chk("fault", 32'(fault), 32'(d.fault));
            end
         end else begin
            chk("rdata_idle_zero", rdata, 32'd0);
         end
      end
   end

   task automatic push_bus(input logic w, input logic [31:0] a, input logic [3:0] be,
                           input logic [31:0] wd, input logic [7:0] len);
      bus_t b;
      b.we = w; b.addr = a; b.be = be; b.wdata = wd; b.len = len;
      bq.push_back(b);
   endtask

   task automatic push_done(input logic [31:0] rd, input logic f);
      done_t d;
      d.rdata = rd; d.fault = f;
      dq.push_back(d);
   endtask

   // One access; lat = cycles from first post-request cycle until done.
   task automatic access(input logic w, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] mrd, input logic [7:0] ackat, output int lat);
      mem_rdata = mrd;
      ack_at = ackat;
      @(posedge clk); #1;
      req = 1'b1; we = w; size = sz; sext = sx; addr = a; wdata = wd;
      @(posedge clk); #1;
      // Scramble inputs: the latched copy must be used.
      req = 1'b0; we = ~w; size = 2'b11; sext = ~sx; addr = 32'hFFFF_FFFF; wdata = ~wd;
      lat = 0;
      while (!done && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      if (lat >= 40) chk("done_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      chk("idle_after_done", 32'(busy), 32'd0);
   endtask

   initial begin
      int lat;
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_m_req", 32'(m_req), 32'd0);
      chk("rst_m_bus", {m_addr[31:6], m_be, m_we, 1'b0}, 32'd0);
      chk("rst_m_wdata", m_wdata, 32'd0);
      chk("rst_fault", 32'(fault), 32'd0);
      rst_n = 1'b1;

      // Byte store, minimum latency
      push_bus(1'b1, 32'h100, 4'b1000, 32'hA5A5A5A5, 8'd1);
      push_done(32'd0, 1'b0);
      access(1'b1, 2'b10, 1'b0, 32'h103, 32'h000000A5, 32'd0, 8'd0, lat);
      chk("byte_store_lat", 32'(lat), 32'd1);

      // Half loads, signed and unsigned
      push_bus(1'b0, 32'h20, 4'b1100, 32'd0, 8'd1);
      push_done(32'hFFFF80FF, 1'b0);
      access(1'b0, 2'b01, 1'b1, 32'h22, 32'd0, 32'h80FF1234, 8'd0, lat);
      push_bus(1'b0, 32'h20, 4'b1100, 32'd0, 8'd1);
      push_done(32'h000080FF, 1'b0);
      access(1'b0, 2'b01, 1'b0, 32'h22, 32'd0, 32'h80FF1234, 8'd0, lat);

      // Byte load, lane 1, signed
      push_bus(1'b0, 32'h40, 4'b0010, 32'd0, 8'd1);
      push_done(32'hFFFFFF80, 1'b0);
      access(1'b0, 2'b10, 1'b1, 32'h41, 32'd0, 32'h12348056, 8'd0, lat);

      // Half store, low lane
      push_bus(1'b1, 32'h10, 4'b0011, 32'hBEEFBEEF, 8'd1);
      push_done(32'd0, 1'b0);
      access(1'b1, 2'b01, 1'b0, 32'h10, 32'hDEADBEEF, 32'd0, 8'd0, lat);

      // Word store with two wait cycles
      push_bus(1'b1, 32'h204, 4'b1111, 32'hCAFEF00D, 8'd3);
      push_done(32'd0, 1'b0);
      access(1'b1, 2'b00, 1'b0, 32'h204, 32'hCAFEF00D, 32'd0, 8'd2, lat);
      chk("wait_lat", 32'(lat), 32'd3);

      // Timeout: never acked
      push_bus(1'b0, 32'h300, 4'b1111, 32'd0, 8'(TO));
      push_done(32'd0, 1'b1);
      access(1'b0, 2'b00, 1'b0, 32'h300, 32'd0, 32'h55555555, 8'hFF, lat);
      chk("timeout_lat", 32'(lat), 32'(TO));

      // Ack in the timeout cycle wins
      push_bus(1'b0, 32'h304, 4'b1111, 32'd0, 8'(TO));
      push_done(32'h11223344, 1'b0);
      access(1'b0, 2'b00, 1'b0, 32'h304, 32'd0, 32'h11223344, 8'(TO - 1), lat);

      // Misaligned word and half loads
`ifdef DM_MASTER_MISALIGN_TRAP_EN
      push_done(32'd0, 1'b1);
      access(1'b0, 2'b00, 1'b0, 32'h6, 32'd0, 32'hA5A55A5A, 8'd0, lat);
      chk("mis_word_lat", 32'(lat), 32'd0);
      push_done(32'd0, 1'b1);
      access(1'b0, 2'b01, 1'b1, 32'h23, 32'd0, 32'h7FFF0000, 8'd0, lat);
`else
      push_bus(1'b0, 32'h4, 4'b1111, 32'd0, 8'd1);
      push_done(32'hA5A55A5A, 1'b0);
      access(1'b0, 2'b00, 1'b0, 32'h6, 32'd0, 32'hA5A55A5A, 8'd0, lat);
      chk("mis_word_lat", 32'(lat), 32'd1);
      push_bus(1'b0, 32'h20, 4'b1100, 32'd0, 8'd1);
      push_done(32'h00007FFF, 1'b0);
      access(1'b0, 2'b01, 1'b1, 32'h23, 32'd0, 32'h7FFF0000, 8'd0, lat);
`endif

      // Stray ack in IDLE is ignored
      ack_force = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("stray_ack_busy", 32'(busy), 32'd0);
      end
      ack_force = 1'b0;

      // Reset during ISSUE aborts without done
      push_bus(1'b0, 32'h500, 4'b1111, 32'd0, 8'd0);
      ack_at = 8'hFF;
      @(posedge clk); #1;
      req = 1'b1; we = 1'b0; size = 2'b00; addr = 32'h500; wdata = 32'd0;
      @(posedge clk); #1;
      req = 1'b0;
      @(posedge clk); #2;
      chk("pre_rst_m_req", 32'(m_req), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("async_rst_m_req", 32'(m_req), 32'd0);
      chk("async_rst_busy", 32'(busy), 32'd0);
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;

      // Reserved size: no bus cycle, faulted completion
      push_done(32'd0, 1'b1);
      access(1'b0, 2'b11, 1'b0, 32'h600, 32'd0, 32'hFFFFFFFF, 8'd0, lat);
      chk("rsvd_lat", 32'(lat), 32'd0);

      repeat (4) @(posedge clk);
      #1;
      chk("bus_queue_empty", 32'(bq.size()), 32'd0);
      chk("done_queue_empty", 32'(dq.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got running want finished");
      $fatal(1, "watchdog");
   end

endmodule
